// File: rtl/rr_arb_mux_if.sv
// Channel-side and output-side handshake bundle for the round-robin / fixed-priority arbiter mux.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface rr_arb_mux_if #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_ready;
    logic                    mode;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_ready;

    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_arb_mux.sv
// N-input arbiter feeding a single registered output word; round-robin or fixed priority per cycle.
// Grant is combinational; the output register refills in the same cycle it drains.
module rr_arb_mux #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_arb_mux_if.slave      bus
);

    logic [SEL_W-1:0]  r_last_grant;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_sel;

    logic              w_load_en;
    logic              w_gnt_found;
    logic [SEL_W-1:0]  w_gnt_idx;
    logic [NUM_IN-1:0] w_in_ready;
    logic [WIDTH-1:0]  w_gnt_data;

    assign w_load_en = rst_n && (!r_out_valid || bus.out_ready);

    // Each requester gets a search distance; the smallest distance wins.
    // Fixed priority uses the index itself, round-robin the distance past last_grant.
    always_comb begin : arb
        int best_d;
        int d;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        best_d      = NUM_IN;
        d           = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            d = bus.mode ? i : (i + 2*NUM_IN - 1 - int'(r_last_grant)) % NUM_IN;
            if (bus.in_valid[i] && (d < best_d)) begin
                best_d      = d;
                w_gnt_found = 1'b1;
                w_gnt_idx   = SEL_W'(i);
            end
        end
    end

    always_comb begin
        w_in_ready = '0;
        w_gnt_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_gnt_idx == SEL_W'(i)) begin
                w_in_ready[i] = w_load_en && w_gnt_found;
                w_gnt_data    = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sel    <= '0;
            r_last_grant <= SEL_W'(NUM_IN-1);
        end else if (w_load_en) begin
            if (w_gnt_found) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= w_gnt_data;
                r_out_sel    <= w_gnt_idx;
                r_last_grant <= w_gnt_idx;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios on a 4-input instance, random traffic on 2/4/8-input
// instances checked against a rule-level arbiter model and a per-channel word scoreboard.
module tb_rr_arb_mux;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   s_valid;
    logic [127:0] s_data;
    logic         s_mode;
    logic         s_out_ready;
    int           cur_n;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rr_arb_mux_if #(.WIDTH(16), .NUM_IN(2), .SEL_W(1)) if2 ();
    rr_arb_mux_if #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) if4 ();
    rr_arb_mux_if #(.WIDTH(16), .NUM_IN(8), .SEL_W(3)) if8 ();

    assign if2.in_valid  = s_valid[1:0];
    assign if2.in_data   = s_data[31:0];
    assign if2.mode      = s_mode;
    assign if2.out_ready = s_out_ready;
    assign if4.in_valid  = s_valid[3:0];
    assign if4.in_data   = s_data[63:0];
    assign if4.mode      = s_mode;
    assign if4.out_ready = s_out_ready;
    assign if8.in_valid  = s_valid;
    assign if8.in_data   = s_data;
    assign if8.mode      = s_mode;
    assign if8.out_ready = s_out_ready;

    rr_arb_mux #(.WIDTH(16), .NUM_IN(2), .SEL_W(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    rr_arb_mux #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    rr_arb_mux #(.WIDTH(16), .NUM_IN(8), .SEL_W(3)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    logic [7:0]  d_ready;
    logic        d_ov;
    logic [15:0] d_od;
    logic [2:0]  d_os;

    always_comb begin
        d_ready = '0;
        d_ov    = 1'b0;
        d_od    = '0;
        d_os    = '0;
        case (cur_n)
            2: begin
                d_ready[1:0] = if2.in_ready;
                d_ov         = if2.out_valid;
                d_od         = if2.out_data;
                d_os[0]      = if2.out_sel;
            end
            8: begin
                d_ready = if8.in_ready;
                d_ov    = if8.out_valid;
                d_od    = if8.out_data;
                d_os    = if8.out_sel;
            end
            default: begin
                d_ready[3:0] = if4.in_ready;
                d_ov         = if4.out_valid;
                d_od         = if4.out_data;
                d_os[1:0]    = if4.out_sel;
            end
        endcase
    end

    // Reference: arbitration rules stated directly, plus per-channel FIFOs of accepted words.
    int          m_last;
    bit          m_ov;
    logic [15:0] m_od;
    int          m_os;
    logic [15:0] q[8][$];
    logic [7:0]  seen_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = cur_n - 1;
        m_ov   = 1'b0;
        m_od   = '0;
        m_os   = 0;
        for (int i = 0; i < 8; i++) q[i].delete();
    endtask

    task automatic step();
        int         g;
        int         c;
        bit         le;
        logic [7:0] exp_rdy;
        logic [15:0] w;
        @(negedge clk);
        seen_ready = d_ready;
        g  = -1;
        le = rst_n && (!m_ov || s_out_ready);
        if (s_mode) begin
            for (int i = 0; i < cur_n; i++)
                if (s_valid[i] && g < 0) g = i;
        end else begin
            for (int k = 1; k <= cur_n; k++) begin
                c = (m_last + k) % cur_n;
                if (s_valid[c] && g < 0) g = c;
            end
        end
        exp_rdy = (le && g >= 0) ? 8'(1 << g) : 8'h00;
        check("in_ready", 32'(seen_ready), 32'(exp_rdy));
        check("in_ready_onehot", 32'($countones(seen_ready) <= 1), 32'd1);

        if (!rst_n) begin
            model_reset();
        end else begin
            if (d_ov && s_out_ready) begin
                check("sb_word_pending", 32'(q[d_os].size() != 0), 32'd1);
                if (q[d_os].size() != 0) begin
                    w = q[d_os].pop_front();
                    check("sb_order", 32'(d_od), 32'(w));
                end
            end
            for (int i = 0; i < cur_n; i++)
                if (seen_ready[i] && s_valid[i]) q[i].push_back(s_data[i*16 +: 16]);
            if (le) begin
                if (g >= 0) begin
                    m_ov   = 1'b1;
                    m_od   = s_data[g*16 +: 16];
                    m_os   = g;
                    m_last = g;
                end else begin
                    m_ov = 1'b0;
                end
            end
        end

        @(posedge clk);
        #1;
        check("out_valid", 32'(d_ov), 32'(m_ov));
        check("out_sel",   32'(d_os), 32'(m_os));
        check("out_data",  32'(d_od), 32'(m_od));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid = '0;
        s_out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        s_valid     = '0;
        s_data      = '0;
        s_mode      = 1'b0;
        s_out_ready = 1'b0;
        cur_n       = 4;
        model_reset();

        do_reset();
        check("rst_out_valid", 32'(d_ov), 32'd0);
        check("rst_out_sel",   32'(d_os), 32'd0);
        check("rst_out_data",  32'(d_od), 32'd0);

        // Round-robin over four busy channels
        s_valid     = 8'h0F;
        s_data      = '0;
        s_data[63:0] = 64'h4444_3333_2222_1111;
        s_out_ready = 1'b1;
        s_mode      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_seq_sel",  32'(d_os), 32'(i % 4));
            check("rr_seq_data", 32'(d_od), 32'(16'h1111 * ((i % 4) + 1)));
        end

        // Fixed priority, channel 3 must lose to channel 1
        s_mode  = 1'b1;
        s_valid = 8'h0A;
        for (int i = 0; i < 4; i++) begin
            step();
            check("fp_ready", 32'(seen_ready), 32'h2);
            check("fp_sel",   32'(d_os), 32'd1);
        end

        // Stall holds the word; release refills with no bubble
        s_valid       = 8'h01;
        s_data[15:0]  = 16'hABCD;
        step();
        check("stall_load", 32'(d_od), 32'hABCD);
        s_out_ready   = 1'b0;
        s_data[15:0]  = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_ready", 32'(seen_ready), 32'h0);
            check("stall_data",  32'(d_od), 32'hABCD);
        end
        s_out_ready = 1'b1;
        step();
        check("unstall_ready", 32'(seen_ready), 32'h1);
        check("unstall_valid", 32'(d_ov), 32'd1);
        check("unstall_data",  32'(d_od), 32'h5555);

        // Wrap-around from last_grant = 3
        s_mode  = 1'b0;
        s_valid = 8'h08;
        step();
        check("wrap_setup_sel", 32'(d_os), 32'd3);
        s_valid = 8'h09;
        step();
        check("wrap_sel0", 32'(d_os), 32'd0);
        step();
        check("wrap_sel3", 32'(d_os), 32'd3);

        // Reset while a word is stalled in the output register
        s_out_ready = 1'b0;
        s_valid     = 8'h04;
        rst_n       = 1'b0;
        step();
        check("midrst_ready", 32'(seen_ready), 32'h0);
        check("midrst_valid", 32'(d_ov), 32'd0);
        check("midrst_sel",   32'(d_os), 32'd0);
        rst_n = 1'b1;
        step();
        check("postrst_ready", 32'(seen_ready), 32'h4);
        check("postrst_sel",   32'(d_os), 32'd2);

        // Random traffic on every channel count
        for (int p = 0; p < 3; p++) begin
            cur_n = (p == 0) ? 2 : (p == 1) ? 8 : 4;
            model_reset();
            do_reset();
            for (int t = 0; t < 300; t++) begin
                s_valid     = 8'($urandom);
                for (int i = 0; i < 8; i++) s_data[i*16 +: 16] = 16'($urandom);
                s_mode      = ($urandom_range(0, 3) == 0);
                s_out_ready = ($urandom_range(0, 2) != 0);
                step();
            end
            s_valid     = '0;
            s_out_ready = 1'b1;
            step();
            step();
            for (int i = 0; i < cur_n; i++)
                check("sb_drained", 32'(q[i].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter WIDTH, default 16, data width of every input and the output (legal range 1..32).
REQ-002 Parameter NUM_IN, default 4, number of input channels (legal range 2..8).
REQ-003 Parameter SEL_W, default 2, index width; SHALL equal ceil(log2(NUM_IN)).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 in_valid  input  NUM_IN  per-channel request; bit i belongs to channel i.
REQ-007 in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_ready  output  NUM_IN  per-channel accept; at most one bit high per cycle.
REQ-009 mode  input  1  0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
REQ-010 out_valid  output  1  output register holds a valid word.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_sel  output  SEL_W  index of the channel that supplied out_data.
REQ-013 out_ready  input  1  downstream accept.

Function
REQ-014 A transfer on channel i SHALL occur in any cycle where in_valid[i] and in_ready[i] are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-015 load_en SHALL be (!out_valid || out_ready); no channel SHALL be granted when load_en is 0.
REQ-016 in_ready SHALL be combinational: in_ready[g] = 1 only for the granted channel g, only when load_en = 1 and in_valid[g] = 1; all other bits 0.
REQ-017 in_ready SHALL NOT depend combinationally on out_ready through any path other than load_en.
REQ-018 Round-robin (mode 0): search order starts at (last_grant + 1) mod NUM_IN, wrapping from NUM_IN-1 to 0; first channel with in_valid = 1 wins.
REQ-019 Fixed priority (mode 1): lowest-index channel with in_valid = 1 wins regardless of last_grant.
REQ-020 last_grant (SEL_W-bit register) SHALL update to g on every channel transfer in both modes, and hold otherwise.
REQ-021 On a channel transfer, out_data, out_sel and out_valid SHALL take in_data[g], g and 1 at the next edge (latency 1 cycle, input handshake to out_valid).
REQ-022 If load_en = 1 and no in_valid bit is set, out_valid SHALL go 0 at the next edge; out_data and out_sel SHALL hold.
REQ-023 If load_en = 0, out_valid, out_data and out_sel SHALL hold (stall); input data SHALL NOT be sampled.
REQ-024 Simultaneous output transfer and channel transfer in one cycle SHALL replace the word with no bubble (full throughput, one word per cycle).
REQ-025 mode changes SHALL take effect on the arbitration in the same cycle; last_grant SHALL NOT be altered by a mode change alone.
REQ-026 A single requesting channel SHALL be granted every cycle load_en = 1 in either mode (no starvation by pointer position).

Reset
REQ-027 While rst_n = 0 at a rising edge: out_valid = 0, out_data = 0, out_sel = 0, last_grant = NUM_IN-1 (so the first round-robin search starts at channel 0).
REQ-028 While rst_n = 0, in_ready SHALL be all 0; any word held mid-transfer SHALL be discarded, not delivered.
REQ-029 Function SHALL resume at the first rising edge after rst_n returns to 1.

Verification
REQ-030 Reset, then in_valid = 4'b1111, data 0x1111/0x2222/0x3333/0x4444, out_ready = 1, mode 0 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data matching.
REQ-031 mode 1, in_valid = 4'b1010, out_ready = 1 -> in_ready = 4'b0010 every cycle, out_sel = 1 continuously, channel 3 never granted.
REQ-032 out_valid = 1 holding 0xABCD, out_ready = 0 for 3 cycles with in_valid = 4'b0001 -> in_ready = 0, out_data stays 0xABCD; out_ready = 1 -> next word from channel 0 loaded same cycle with no bubble.
REQ-033 last_grant = 3, in_valid = 4'b1001, mode 0 -> channel 0 granted (wrap-around), then channel 3 next cycle.
REQ-034 rst_n driven 0 for one cycle while out_valid = 1 and out_ready = 0 -> out_valid = 0, out_sel = 0, in_ready = 0; after release with in_valid = 4'b0100 -> out_sel = 2 one cycle later.
REQ-035 Random stimulus, NUM_IN = 2 and NUM_IN = 8, WIDTH = 16 -> scoreboard confirms every accepted word appears exactly once, in order per channel, at most one in_ready bit high.
